// File: rtl/riscv_scoreboard.sv
// Register scoreboard: pending-write tracking, hazard stall, watchdog.
// Optional stall performance counter enabled by RISCV_SB_PERF_EN.
module riscv_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int WDW     = 8,
    parameter int WDLIMIT = 200
) (
    input  logic            i_riscv_sb_clk,
    input  logic            i_riscv_sb_rst,
    input  logic            i_riscv_sb_issue_valid,
    input  logic [AW-1:0]   i_riscv_sb_rd,
    input  logic [AW-1:0]   i_riscv_sb_rs1,
    input  logic [AW-1:0]   i_riscv_sb_rs2,
    input  logic            i_riscv_sb_use_rs1,
    input  logic            i_riscv_sb_use_rs2,
    input  logic            i_riscv_sb_regw,
    input  logic            i_riscv_sb_longlat,
    input  logic            i_riscv_sb_wb_valid,
    input  logic [AW-1:0]   i_riscv_sb_wb_rd,
    input  logic            i_riscv_sb_globstall,
    input  logic            i_riscv_sb_flush,
    output logic            o_riscv_sb_stall,
    output logic            o_riscv_sb_issue,
    output logic [NREG-1:0] o_riscv_sb_busy,
    output logic [AW:0]     o_riscv_sb_busycnt,
    output logic            o_riscv_sb_deadlock,
    output logic [31:0]     o_riscv_sb_stallcnt
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic [WDW-1:0]  wd_q;
    logic [WDW-1:0]  wd_d;
    logic            dl_q;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            stall;
    logic            issue;

    // A writeback landing this cycle already resolves the hazard.
    assign hit_rs1 = busy_q[i_riscv_sb_rs1] &
                     ~(i_riscv_sb_wb_valid &
                       (i_riscv_sb_wb_rd == i_riscv_sb_rs1));
    assign hit_rs2 = busy_q[i_riscv_sb_rs2] &
                     ~(i_riscv_sb_wb_valid &
                       (i_riscv_sb_wb_rd == i_riscv_sb_rs2));
    assign hit_rd  = busy_q[i_riscv_sb_rd] &
                     ~(i_riscv_sb_wb_valid &
                       (i_riscv_sb_wb_rd == i_riscv_sb_rd));

    assign stall = i_riscv_sb_issue_valid & ~i_riscv_sb_flush &
                   ((i_riscv_sb_use_rs1 & hit_rs1) |
                    (i_riscv_sb_use_rs2 & hit_rs2) |
                    (i_riscv_sb_regw & hit_rd));

    assign issue = i_riscv_sb_issue_valid & ~stall &
                   ~i_riscv_sb_globstall & ~i_riscv_sb_flush;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue & i_riscv_sb_regw & i_riscv_sb_longlat &
            (i_riscv_sb_rd != '0))
            set_mask[i_riscv_sb_rd] = 1'b1;
        if (i_riscv_sb_wb_valid)
            clr_mask[i_riscv_sb_wb_rd] = 1'b1;
        // Set is applied after clear so it wins on a collision.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end

    always_comb begin
        if (!stall)
            wd_d = '0;
        else if (wd_q == '1)
            wd_d = wd_q;
        else
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge i_riscv_sb_clk or negedge i_riscv_sb_rst) begin
        if (!i_riscv_sb_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            wd_q   <= '0;
            dl_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            wd_q   <= wd_d;
            if (wd_d == WDW'(WDLIMIT))
                dl_q <= 1'b1;
        end
    end

`ifdef RISCV_SB_PERF_EN
    logic [31:0] sc_q;

    always_ff @(posedge i_riscv_sb_clk or negedge i_riscv_sb_rst) begin
        if (!i_riscv_sb_rst)
            sc_q <= '0;
        else if (stall)
            sc_q <= sc_q + 32'd1;
    end

    assign o_riscv_sb_stallcnt = sc_q;
`else
    assign o_riscv_sb_stallcnt = 32'd0;
`endif

    assign o_riscv_sb_stall    = stall;
    assign o_riscv_sb_issue    = issue;
    assign o_riscv_sb_busy     = busy_q;
    assign o_riscv_sb_busycnt  = cnt_q;
    assign o_riscv_sb_deadlock = dl_q;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Randomised and directed bench for riscv_scoreboard against a
// set-of-pending-registers reference model.
module tb_riscv_scoreboard;

`ifdef RISCV_SB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        iv;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        regw;
    logic        ll;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        gs;
    logic        fl;
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [5:0]  busycnt;
    logic        deadlock;
    logic [31:0] stallcnt;

    int errors = 0;
    int checks = 0;

    bit          pend[int];
    int          run;
    logic [31:0] total;
    bit          dl;

    riscv_scoreboard dut (
        .i_riscv_sb_clk        (clk),
        .i_riscv_sb_rst        (rst),
        .i_riscv_sb_issue_valid(iv),
        .i_riscv_sb_rd         (rd),
        .i_riscv_sb_rs1        (rs1),
        .i_riscv_sb_rs2        (rs2),
        .i_riscv_sb_use_rs1    (u1),
        .i_riscv_sb_use_rs2    (u2),
        .i_riscv_sb_regw       (regw),
        .i_riscv_sb_longlat    (ll),
        .i_riscv_sb_wb_valid   (wbv),
        .i_riscv_sb_wb_rd      (wbrd),
        .i_riscv_sb_globstall  (gs),
        .i_riscv_sb_flush      (fl),
        .o_riscv_sb_stall      (stall),
        .o_riscv_sb_issue      (issue),
        .o_riscv_sb_busy       (busy),
        .o_riscv_sb_busycnt    (busycnt),
        .o_riscv_sb_deadlock   (deadlock),
        .o_riscv_sb_stallcnt   (stallcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input int r);
        return pend.exists(r) && !(wbv && int'(wbrd) == r);
    endfunction

    function automatic bit exp_stall();
        return iv && !fl &&
               ((u1 && hit(int'(rs1))) ||
                (u2 && hit(int'(rs2))) ||
                (regw && hit(int'(rd))));
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [31:0] v = '0;
        foreach (pend[k]) v[k] = 1'b1;
        return v;
    endfunction

    task automatic idle();
        iv = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
        regw = 0; ll = 0; wbv = 0; wbrd = 0; gs = 0; fl = 0;
    endtask

    task automatic instr(input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input bit a,
                         input bit b, input bit w, input bit l);
        iv = 1; rd = d; rs1 = s1; rs2 = s2;
        u1 = a; u2 = b; regw = w; ll = l;
    endtask

    // Called mid-cycle with inputs driven; checks, then advances one cycle.
    task automatic step();
        bit st;
        bit is;
        #1;
        st = exp_stall();
        is = iv && !st && !gs && !fl;
        check("stall", stall, st);
        check("issue", issue, is);
        check("busy", busy, exp_vec());
        check("busycnt", busycnt, pend.num());
        check("deadlock", deadlock, dl);
        check("stallcnt", stallcnt, PERF ? total : 32'd0);
        if (st) begin
            run++;
            total++;
        end else begin
            run = 0;
        end
        if (run >= 200) dl = 1;
        if (wbv) pend.delete(int'(wbrd));
        if (is && regw && ll && rd != 0) pend[int'(rd)] = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_cnt", busycnt, 0);
        check("rst_dl", deadlock, 0);
        check("rst_sc", stallcnt, 0);
        check("rst_stall", stall, 0);
        pend.delete();
        run = 0;
        total = '0;
        dl = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int c;
        idle();
        rst = 1'b0;
        run = 0;
        total = '0;
        dl = 0;
        @(negedge clk);
        do_reset();

        // Load-use hazard resolved by same-cycle writeback.
        instr(5, 0, 0, 0, 0, 1, 1);
        step();
        instr(6, 5, 0, 1, 0, 1, 0);
        #1 check("lu_stall", stall, 1);
        step();
        step();
        wbv = 1; wbrd = 5;
        #1 check("lu_wb_stall", stall, 0);
        check("lu_wb_issue", issue, 1);
        step();
        idle();
        step();

        // Long-latency write to x0 is ignored.
        instr(0, 0, 0, 0, 0, 1, 1);
        step();
        idle();
        #1 check("x0_busy", busy, 0);
        check("x0_cnt", busycnt, 0);
        step();

        // Set and clear on the same register: set wins.
        instr(7, 0, 0, 0, 0, 1, 1);
        step();
        idle();
        step();
        c = pend.num();
        instr(7, 1, 2, 0, 0, 1, 1);
        wbv = 1; wbrd = 7;
        step();
        idle();
        #1 check("sc_bit7", busy[7], 1);
        check("sc_cnt", busycnt, c);
        step();

        // Flush squashes a hazarded instruction.
        instr(3, 0, 0, 0, 0, 1, 1);
        step();
        idle();
        step();
        instr(8, 0, 3, 0, 1, 1, 0);
        fl = 1;
        #1 check("fl_stall", stall, 0);
        check("fl_issue", issue, 0);
        step();
        idle();
        #1 check("fl_bit3", busy[3], 1);
        step();

        // Watchdog on a dependency with no writeback.
        do_reset();
        instr(9, 0, 0, 0, 0, 1, 1);
        step();
        instr(10, 9, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == 199) check("wd_early", deadlock, 0);
        end
        #1 check("wd_set", deadlock, 1);
        idle();
        step();
        step();
        #1 check("wd_sticky", deadlock, 1);
        do_reset();
        check("wd_clr", deadlock, 0);

        // Ten stall cycles for the performance counter.
        instr(11, 0, 0, 0, 0, 1, 1);
        step();
        instr(12, 0, 11, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step();
        idle();
        #1 check("perf10", stallcnt, PERF ? 32'd10 : 32'd0);
        step();

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            iv   = ($urandom_range(0, 3) != 0);
            rd   = 5'($urandom_range(0, 7));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            u1   = 1'($urandom);
            u2   = 1'($urandom);
            regw = 1'($urandom);
            ll   = 1'($urandom);
            wbv  = ($urandom_range(0, 2) == 0);
            wbrd = 5'($urandom_range(0, 7));
            gs   = ($urandom_range(0, 4) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            step();
        end

        // Writebacks after a reset are no-ops on the cleared vector.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            idle();
            wbv = 1;
            wbrd = 5'(r);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
